sng_array: RTL
==============

SNG_ARRAY -- requirements
Module: sng_array

Interface
REQ-001 Parameter WIDTH, default 4, binary input width per channel; legal range 2..8; stream length L = 2^WIDTH.
REQ-002 Parameter CH, default 4, number of independent stochastic channels; legal range 1..16.
REQ-003 Parameter STRIDE, default 5, per-channel phase step; channel c starts at offset (c*STRIDE) mod L.
REQ-004 i_clk_sng  input  1  clock; all state updates on its rising edge.
REQ-005 i_rst_sng  input  1  reset; asynchronous, active-high.
REQ-006 i_start_sng  input  1  request to latch inputs and begin one L-bit stream.
REQ-007 i_stop_sng  input  1  abort the current stream.
REQ-008 i_x_bn  input  CH*WIDTH  unsigned binary values; channel c occupies bits [c*WIDTH +: WIDTH].
REQ-009 o_sn_bits  output  CH  registered stochastic bit per channel, channel c on bit c.
REQ-010 o_valid  output  1  high while o_sn_bits carries a stream bit.
REQ-011 o_busy  output  1  high in GEN state.
REQ-012 o_done  output  1  one-cycle pulse after a stream completes without abort.

Function
REQ-013 States SHALL be IDLE, GEN, DONE; encoding is free.
REQ-014 IDLE: i_start_sng=1 -> latch i_x_bn into internal registers, clear index k to 0, go to GEN; otherwise stay.
REQ-015 GEN: each cycle emits one bit per channel, increments k; after k = L-1 is emitted, go to DONE.
REQ-016 DONE: lasts exactly one cycle with o_done=1; i_start_sng=1 in DONE latches and goes to GEN (back-to-back streams, no idle gap); otherwise go to IDLE.
REQ-017 Latency: start sampled at edge t -> first valid bit visible after edge t+1; o_valid high for exactly L consecutive cycles.
REQ-018 Bit rule: for channel c, j = (k + c*STRIDE) mod L; m = trailing-zero count of (j+1) in WIDTH+1 bits; bit = x_c[WIDTH-1-m] if m < WIDTH, else 0.
REQ-019 Over one full stream, each channel SHALL emit exactly x_c ones (x_c=0 -> all zeros; x_c=L-1 -> exactly one zero).
REQ-020 o_sn_bits SHALL be 0 whenever o_valid=0.
REQ-021 i_x_bn changes during GEN SHALL NOT affect the current stream; only the latched copy is used.
REQ-022 i_start_sng in GEN is ignored.
REQ-023 i_stop_sng in GEN -> next state IDLE, o_valid=0 and o_busy=0 from the next cycle, no o_done.
REQ-024 i_stop_sng on the cycle of the final bit (k = L-1) has priority: IDLE, no o_done.
REQ-025 i_stop_sng in IDLE or DONE is ignored; i_start_sng and i_stop_sng together in IDLE -> start is accepted.
REQ-026 k SHALL be WIDTH bits wide and wrap only via the GEN->DONE exit, never mid-stream.

Reset
REQ-027 i_rst_sng=1 SHALL immediately force IDLE, k=0, latched inputs=0, o_sn_bits=0, o_valid=0, o_busy=0, o_done=0, including mid-stream.
REQ-028 After reset deassertion, the first stream starts only on a new i_start_sng.

Verification
REQ-029 WIDTH=4, CH=4, x={3,0,15,8}, start pulse -> 16 valid cycles; per-channel ones counts 3,0,15,8; o_done pulses once on cycle 18.
REQ-030 Channel 0, x=4'b1010, STRIDE=5 -> channel 0 sequence matches REQ-018 bit-for-bit (1,0,1,1,1,0,1,0,1,0,1,1,1,0,1,0 for k=0..15); channel 1 is the same sequence rotated by 5.
REQ-031 Stop asserted at k=6 -> o_valid low from the following cycle, no o_done, next start yields a full 16-bit stream.
REQ-032 Start held high continuously -> back-to-back streams, pattern valid 16, done 1, valid 16...; no gap cycle beyond DONE.
REQ-033 Asynchronous reset pulse between clock edges at k=9 -> all outputs 0 immediately; i_x_bn changed mid-stream -> counts reflect the latched value.
REQ-034 WIDTH=8, CH=1, x=255 -> 256 valid cycles with exactly 255 ones; the single zero occurs at j=255.

Source files
------------

// File: rtl/sng_array_if.sv
// sng_array_if: control/data bundle for the stochastic number generator array.
//   i_start_sng : request to latch i_x_bn and begin one L-bit stream
//   i_stop_sng  : abort the stream in progress
//   i_x_bn      : CH unsigned WIDTH-bit values, channel c at [c*WIDTH +: WIDTH]
//   o_sn_bits   : registered stochastic bit per channel (channel c on bit c)
//   o_valid     : o_sn_bits carries a stream bit
//   o_busy      : generator is in its GEN state
//   o_done      : one-cycle pulse after a stream completes without abort
// master drives requests/data, slave (the generator) drives results.
interface sng_array_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CH    = 4
);
  logic                  i_start_sng;
  logic                  i_stop_sng;
  logic [CH*WIDTH-1:0]   i_x_bn;
  logic [CH-1:0]         o_sn_bits;
  logic                  o_valid;
  logic                  o_busy;
  logic                  o_done;

  modport master (
    output i_start_sng, i_stop_sng, i_x_bn,
    input  o_sn_bits, o_valid, o_busy, o_done
  );

  modport slave (
    input  i_start_sng, i_stop_sng, i_x_bn,
    output o_sn_bits, o_valid, o_busy, o_done
  );
endinterface

// File: rtl/sng_array.sv
// sng_array: CH-channel stochastic number generator. On start, the binary
// inputs are latched and an L = 2^WIDTH bit stream is produced per channel in
// which channel c carries exactly x_c ones. Bits follow a low-discrepancy
// ordering: for stream index j, the bit is x_c[WIDTH-1-m] where m is the
// trailing-zero count of (j+1); j = L-1 always yields 0. Each channel walks
// the same ordering from phase offset (c*STRIDE) mod L.
// Ports:
//   i_clk_sng : clock, rising edge
//   i_rst_sng : asynchronous active-high reset
//   bus       : sng_array_if slave modport (start/stop/x in, bits/valid/busy/done out)
module sng_array #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned CH     = 4,
  parameter int unsigned STRIDE = 5
) (
  input logic       i_clk_sng,
  input logic       i_rst_sng,
  sng_array_if.slave bus
);

  typedef enum logic [1:0] {IDLE, GEN, DONE} state_t;

  localparam logic [WIDTH-1:0] K_LAST = '1;
  localparam logic [WIDTH-1:0] K_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH:0]   J_ONE  = {{WIDTH{1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    k_q, k_d;
  logic [CH*WIDTH-1:0] x_q, x_d;
  logic [CH-1:0]       sn_q, sn_d;
  logic [CH-1:0]       bits;
  logic                valid_q, valid_d;
  logic                done_q, done_d;

  // Selects the input bit weighted by the lowest set bit of (j+1).
  function automatic logic stoch_bit(input logic [WIDTH-1:0] xc,
                                     input logic [WIDTH-1:0] j);
    logic [WIDTH:0] jp1;
    logic           b;
    logic           found;
    jp1   = {1'b0, j} + J_ONE;
    b     = 1'b0;
    found = 1'b0;
    for (int unsigned m = 0; m < WIDTH; m++) begin
      if (!found && jp1[m]) begin
        b     = xc[WIDTH-1-m];
        found = 1'b1;
      end
    end
    return b;
  endfunction

  // WIDTH-bit addition wraps, giving (k + c*STRIDE) mod L directly.
  always_comb begin : bit_gen
    bits = '0;
    for (int unsigned c = 0; c < CH; c++) begin
      bits[c] = stoch_bit(x_q[c*WIDTH +: WIDTH], k_q + WIDTH'(c * STRIDE));
    end
  end

  always_comb begin : next_state
    state_d = state_q;
    k_d     = k_q;
    x_d     = x_q;
    unique case (state_q)
      IDLE: begin
        if (bus.i_start_sng) begin
          x_d     = bus.i_x_bn;
          k_d     = '0;
          state_d = GEN;
        end
      end
      GEN: begin
        if (bus.i_stop_sng) begin
          k_d     = '0;
          state_d = IDLE;
        end else begin
          k_d = k_q + K_ONE;
          if (k_q == K_LAST) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (bus.i_start_sng) begin
          x_d     = bus.i_x_bn;
          k_d     = '0;
          state_d = GEN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bit k is computed while in GEN and registered on the same edge that
  // advances k, so the stream trails the state by one cycle. The done pulse
  // is registered from DONE so it lands in the cycle right after the final
  // bit rather than overlapping it.
  always_comb begin : out_next
    valid_d = (state_q == GEN) && !bus.i_stop_sng;
    sn_d    = valid_d ? bits : '0;
    done_d  = (state_q == DONE);
  end

  always_ff @(posedge i_clk_sng or posedge i_rst_sng) begin
    if (i_rst_sng) begin
      state_q <= IDLE;
      k_q     <= '0;
      x_q     <= '0;
      sn_q    <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      x_q     <= x_d;
      sn_q    <= sn_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign bus.o_sn_bits = sn_q;
  assign bus.o_valid   = valid_q;
  assign bus.o_done    = done_q;
  assign bus.o_busy    = (state_q == GEN);

endmodule
